// File: rtl/convolution_coprocessor_stream_mux.sv
// convolution_coprocessor_stream_mux
// Purpose: N-channel packet stream selector feeding the MAC pipeline. One input
// channel is granted (explicit select or round-robin) and held until its last beat.
// Accepted beats land in a single registered output slot.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mode_rr, sel             arbitration mode / explicit channel (sampled in IDLE)
//   in_data/valid/last       flattened per-channel input streams
//   in_ready                 per-channel accept (combinational from state/out_ready)
//   out_data/valid/last/ch   registered output beat and its source channel
//   out_ready                downstream accept
//   busy                     high while a channel is locked
//   err_sel                  one-cycle flag for an out-of-range explicit select
module convolution_coprocessor_stream_mux #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_CH       = 4,
    localparam int unsigned SEL_W     = $clog2(N_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode_rr,
    input  logic [SEL_W-1:0]           sel,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]            in_valid,
    input  logic [N_CH-1:0]            in_last,
    output logic [N_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [SEL_W-1:0]           out_ch,
    output logic                       busy,
    output logic                       err_sel
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [DATA_WIDTH-1:0] cur_data_c;
    logic                  cur_valid_c;
    logic                  cur_last_c;
    logic                  space_c;
    logic                  accept_c;
    logic                  sel_bad_c;
    logic                  sel_valid_c;
    logic                  rr_found_c;
    logic [SEL_W-1:0]      rr_pick_c;

    // Mux the locked channel's beat out of the flattened inputs
    always_comb begin
        cur_data_c  = '0;
        cur_valid_c = 1'b0;
        cur_last_c  = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (cur_q == SEL_W'(i)) begin
                cur_data_c  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                cur_valid_c = in_valid[i];
                cur_last_c  = in_last[i];
            end
        end
    end

    // Explicit select: range check and requested channel's valid
    always_comb begin
        sel_bad_c   = ({1'b0, sel} >= (SEL_W+1)'(N_CH));
        sel_valid_c = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (sel == SEL_W'(i)) begin
                sel_valid_c = in_valid[i];
            end
        end
    end

    // Round-robin pick: lowest valid channel at/after rr_ptr, else lowest valid overall
    always_comb begin
        rr_found_c = 1'b0;
        rr_pick_c  = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_found_c = 1'b1;
                rr_pick_c  = SEL_W'(i);
            end
        end
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (in_valid[i] && (SEL_W'(i) >= rr_ptr_q)) begin
                rr_pick_c = SEL_W'(i);
            end
        end
    end

    // Output slot has room when empty or draining this cycle
    assign space_c  = ~out_valid | out_ready;
    assign accept_c = (state_q == LOCK) & cur_valid_c & space_c;
    assign busy     = (state_q == LOCK);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FSM next-state, grant and per-channel ready
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        rr_ptr_d = rr_ptr_q;
        in_ready = '0;
        case (state_q)
            IDLE: begin
                if (!mode_rr) begin
                    if (!sel_bad_c && sel_valid_c) begin
                        cur_d   = sel;
                        state_d = LOCK;
                    end
                end else if (rr_found_c) begin
                    cur_d   = rr_pick_c;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    if (space_c && (cur_q == SEL_W'(i))) begin
                        in_ready[i] = 1'b1;
                    end
                end
                if (accept_c && cur_last_c) begin
                    state_d  = IDLE;
                    rr_ptr_d = (cur_q == SEL_W'(N_CH - 1)) ? '0 : cur_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered output slot; a new beat may replace a draining one in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            err_sel   <= 1'b0;
        end else begin
            err_sel <= (state_q == IDLE) & ~mode_rr & sel_bad_c;
            if (accept_c) begin
                out_valid <= 1'b1;
                out_data  <= cur_data_c;
                out_last  <= cur_last_c;
                out_ch    <= cur_q;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
